// File: rtl/rr_request_agent.sv
// Client-side agent for a round-robin arbiter: queues per-channel requests,
// drives req, accepts a one-hot grant, runs a fixed burst and returns ack.
module rr_request_agent #(
    parameter int WIDTH = 4,
    parameter int BURST = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push,
    input  logic [WIDTH-1:0] grant,
    output logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] pend_full,
    output logic [WIDTH-1:0] served,
    output logic             ack,
    output logic             busy,
    output logic             err
);

    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [WIDTH-1:0]            served_q, served_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic                        err_q, err_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        last_beat;
    logic                        grant_hit;
    logic [WIDTH-1:0]            cnt_dec;
    logic [WIDTH-1:0]            cnt_inc;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != {WIDTH{1'b0}}) && ((v & (v - WIDTH'(1))) == {WIDTH{1'b0}});
    endfunction

    assign last_beat = (state_q == ST_XFER) && (beat_q == LAST_BEAT);
    assign grant_hit = |(grant & served_q);

    // Next-state logic for the burst FSM.
    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        beat_d   = beat_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant == {WIDTH{1'b0}}) begin
                    state_d = ST_IDLE;
                end else if (is_onehot(grant) && ((grant & req) != {WIDTH{1'b0}})) begin
                    served_d = grant;
                    beat_d   = {BEAT_W{1'b0}};
                    state_d  = ST_XFER;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_XFER: begin
                // The last beat is committed once ack is showing, so a grant drop there is not an abort.
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_RELEASE;
                end else if (grant_hit) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    served_d = {WIDTH{1'b0}};
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                served_d = {WIDTH{1'b0}};
            end
            default: begin
                state_d  = ST_IDLE;
                served_d = {WIDTH{1'b0}};
                beat_d   = {BEAT_W{1'b0}};
            end
        endcase
    end

    // Pending counters: a push racing a completion is always accepted, even when full.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_dec = {WIDTH{1'b0}};
        cnt_inc = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_dec[i] = last_beat && served_q[i];
            cnt_inc[i] = push[i] && ((cnt_q[i] != CNT_MAX) || cnt_dec[i]);
            if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!cnt_inc[i] && cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Output decodes, all taken from registered state.
    always_comb begin
        req       = {WIDTH{1'b0}};
        pend_full = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            req[i]       = (cnt_q[i] != {CNT_W{1'b0}}) && !((state_q == ST_RELEASE) && served_q[i]);
            pend_full[i] = (cnt_q[i] == CNT_MAX);
        end
        if (state_q == ST_XFER) begin
            served = served_q;
        end else begin
            served = {WIDTH{1'b0}};
        end
        ack  = last_beat;
        busy = (state_q != ST_IDLE);
        err  = err_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            served_q <= {WIDTH{1'b0}};
            beat_q   <= {BEAT_W{1'b0}};
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_request_agent.sv
// Directed self-checking bench for rr_request_agent (WIDTH=4, BURST=2, CNT_W=2).
module tb_rr_request_agent;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] push;
    logic [3:0] grant;
    logic [3:0] req;
    logic [3:0] pend_full;
    logic [3:0] served;
    logic       ack;
    logic       busy;
    logic       err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    rr_request_agent #(.WIDTH(4), .BURST(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .grant     (grant),
        .req       (req),
        .pend_full (pend_full),
        .served    (served),
        .ack       (ack),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full service (accept, BURST beats, release) and tallies ack/err pulses.
    task automatic serve(input logic [3:0] g, output int acks, output int errs);
        acks  = 0;
        errs  = 0;
        grant = g;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (ack) acks++;
            if (err) errs++;
            if (k == 2) grant = 4'b0000;
            tick();
        end
        if (ack) acks++;
        if (err) errs++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push  = 4'($urandom);
            grant = 4'($urandom);
            tick();
            vec_cnt++;
            if ({req, pend_full, served, ack, busy, err} !== 15'd0) begin
                miss_cnt++;
                $display("FAIL reset_outputs got %h exp 0000", {req, pend_full, served, ack, busy, err});
            end
        end
        push  = 4'b0000;
        grant = 4'b0000;
        rst   = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if ({req, busy, err} !== 6'b0000_0_0) begin
            miss_cnt++;
            $display("FAIL reset_release got req=%b busy=%b err=%b exp 0000 0 0", req, busy, err);
        end
    endtask

    task automatic test_single();
        push = 4'b0010;
        tick();
        push = 4'b0000;
        vec_cnt++;
        if (req !== 4'b0010) begin
            miss_cnt++;
            $display("FAIL single_req got %b exp 0010", req);
        end
        grant = 4'b0010;
        tick();
        vec_cnt++;
        if ({served, ack, busy} !== 6'b0010_0_1) begin
            miss_cnt++;
            $display("FAIL single_beat0 got %b exp 001001", {served, ack, busy});
        end
        tick();
        vec_cnt++;
        if ({served, ack, busy} !== 6'b0010_1_1) begin
            miss_cnt++;
            $display("FAIL single_beat1 got %b exp 001011", {served, ack, busy});
        end
        tick();
        grant = 4'b0000;
        vec_cnt++;
        if ({req, served, ack, busy} !== 10'b0000_0000_0_1) begin
            miss_cnt++;
            $display("FAIL single_release got %b exp 0000000001", {req, served, ack, busy});
        end
        tick();
        vec_cnt++;
        if ({req, pend_full, busy, err} !== 10'b0000_0000_0_0) begin
            miss_cnt++;
            $display("FAIL single_idle got %b exp 0000000000", {req, pend_full, busy, err});
        end
    endtask

    task automatic test_saturation();
        int a, e, tot_a, tot_e;
        logic [3:0] exp_full;
        for (int k = 0; k < 4; k++) begin
            push = 4'b0001;
            tick();
            push     = 4'b0000;
            exp_full = (k >= 2) ? 4'b0001 : 4'b0000;
            vec_cnt++;
            if ({req, pend_full} !== {4'b0001, exp_full}) begin
                miss_cnt++;
                $display("FAIL sat_push%0d got req=%b full=%b exp 0001 %b", k, req, pend_full, exp_full);
            end
        end
        grant = 4'b0001;
        tick();
        tick();
        vec_cnt++;
        if (ack !== 1'b1) begin
            miss_cnt++;
            $display("FAIL sat_ack got %b exp 1", ack);
        end
        push = 4'b0001;
        tick();
        push  = 4'b0000;
        grant = 4'b0000;
        vec_cnt++;
        if ({req, pend_full} !== 8'b0000_0001) begin
            miss_cnt++;
            $display("FAIL sat_release got %b exp 00000001", {req, pend_full});
        end
        tick();
        vec_cnt++;
        if ({req, pend_full} !== 8'b0001_0001) begin
            miss_cnt++;
            $display("FAIL sat_full_kept got %b exp 00010001", {req, pend_full});
        end
        tot_a = 0;
        tot_e = 0;
        for (int k = 0; k < 3; k++) begin
            serve(4'b0001, a, e);
            tot_a += a;
            tot_e += e;
        end
        vec_cnt++;
        if ({tot_a, tot_e} !== {32'd3, 32'd0}) begin
            miss_cnt++;
            $display("FAIL sat_drain got acks=%0d errs=%0d exp 3 0", tot_a, tot_e);
        end
        vec_cnt++;
        if ({req, pend_full} !== 8'b0000_0000) begin
            miss_cnt++;
            $display("FAIL sat_empty got %b exp 00000000", {req, pend_full});
        end
    endtask

    task automatic test_illegal();
        int a1, e1, a2, e2;
        push = 4'b0110;
        tick();
        push  = 4'b0000;
        grant = 4'b0110;
        tick();
        grant = 4'b0000;
        vec_cnt++;
        if ({err, busy, req} !== 6'b1_0_0110) begin
            miss_cnt++;
            $display("FAIL illegal_multi got %b exp 100110", {err, busy, req});
        end
        tick();
        vec_cnt++;
        if ({err, busy} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL illegal_pulse got %b exp 00", {err, busy});
        end
        grant = 4'b1000;
        tick();
        grant = 4'b0000;
        vec_cnt++;
        if ({err, busy} !== 2'b10) begin
            miss_cnt++;
            $display("FAIL illegal_noreq got %b exp 10", {err, busy});
        end
        tick();
        vec_cnt++;
        if ({err, busy, req} !== 6'b0_0_0110) begin
            miss_cnt++;
            $display("FAIL illegal_after got %b exp 000110", {err, busy, req});
        end
        serve(4'b0010, a1, e1);
        serve(4'b0100, a2, e2);
        vec_cnt++;
        if ({a1 + a2, e1 + e2, 28'd0, req} !== {32'd2, 32'd0, 28'd0, 4'b0000}) begin
            miss_cnt++;
            $display("FAIL illegal_cleanup got acks=%0d errs=%0d req=%b exp 2 0 0000", a1 + a2, e1 + e2, req);
        end
    endtask

    task automatic test_abort();
        int a, e;
        push = 4'b0001;
        tick();
        push  = 4'b0000;
        grant = 4'b0001;
        tick();
        vec_cnt++;
        if ({served, busy} !== 5'b0001_1) begin
            miss_cnt++;
            $display("FAIL abort_accept got %b exp 00011", {served, busy});
        end
        grant = 4'b0000;
        tick();
        vec_cnt++;
        if ({err, busy, served, req} !== 10'b1_0_0000_0001) begin
            miss_cnt++;
            $display("FAIL abort_err got %b exp 1000000001", {err, busy, served, req});
        end
        tick();
        vec_cnt++;
        if ({err, req} !== 5'b0_0001) begin
            miss_cnt++;
            $display("FAIL abort_after got %b exp 00001", {err, req});
        end
        serve(4'b0001, a, e);
        vec_cnt++;
        if (a !== 1 || e !== 0 || req !== 4'b0000) begin
            miss_cnt++;
            $display("FAIL abort_retry got acks=%0d errs=%0d req=%b exp 1 0 0000", a, e, req);
        end
    endtask

    task automatic test_reset_mid_burst();
        push = 4'b0100;
        tick();
        push  = 4'b0000;
        grant = 4'b0100;
        tick();
        rst = 1'b0;
        tick();
        vec_cnt++;
        if ({req, pend_full, served, ack, busy, err} !== 15'd0) begin
            miss_cnt++;
            $display("FAIL midreset_outputs got %h exp 0000", {req, pend_full, served, ack, busy, err});
        end
        rst   = 1'b1;
        grant = 4'b0000;
        tick();
        tick();
        vec_cnt++;
        if ({req, busy, err} !== 6'b0000_0_0) begin
            miss_cnt++;
            $display("FAIL midreset_discard got %b exp 000000", {req, busy, err});
        end
    endtask

    task automatic test_back_to_back();
        int seq [8];
        int acks, errs, cyc, ptr, idx;
        logic [3:0] g;
        for (int k = 0; k < 8; k++) seq[k] = -1;
        push = 4'b1111;
        tick();
        tick();
        push = 4'b0000;
        vec_cnt++;
        if ({req, pend_full} !== 8'b1111_0000) begin
            miss_cnt++;
            $display("FAIL rr_setup got %b exp 11110000", {req, pend_full});
        end
        acks = 0;
        errs = 0;
        cyc  = 0;
        ptr  = 0;
        g    = 4'b0000;
        for (int n = 0; n < 64 && !(acks == 8 && !busy); n++) begin
            if (ack) begin
                idx = -1;
                for (int j = 0; j < 4; j++) if (served[j]) idx = j;
                if (acks < 8) seq[acks] = idx;
                acks++;
            end
            if (err) errs++;
            // Round-robin arbiter model: decides only while the agent is idle.
            if (!busy) begin
                g = 4'b0000;
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (ptr + k) % 4;
                    if (g == 4'b0000 && req[c]) begin
                        g   = 4'b0001 << c;
                        ptr = (c + 1) % 4;
                    end
                end
            end
            if (busy || g != 4'b0000) cyc++;
            grant = g;
            tick();
        end
        grant = 4'b0000;
        vec_cnt++;
        if (acks !== 8 || errs !== 0) begin
            miss_cnt++;
            $display("FAIL rr_counts got acks=%0d errs=%0d exp 8 0", acks, errs);
        end
        vec_cnt++;
        if (cyc !== 32) begin
            miss_cnt++;
            $display("FAIL rr_cycles got %0d exp 32", cyc);
        end
        for (int k = 0; k < 8; k++) begin
            vec_cnt++;
            if (seq[k] !== k % 4) begin
                miss_cnt++;
                $display("FAIL rr_order%0d got %0d exp %0d", k, seq[k], k % 4);
            end
        end
        vec_cnt++;
        if ({req, busy} !== 5'b0000_0) begin
            miss_cnt++;
            $display("FAIL rr_drained got %b exp 00000", {req, busy});
        end
    endtask

    initial begin
        rst   = 1'b0;
        push  = 4'b0000;
        grant = 4'b0000;
        test_reset();
        test_single();
        test_saturation();
        test_illegal();
        test_abort();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_request_agent.md
# rr_request_agent

Client-side counterpart of the round-robin arbiter: it queues per-channel requests, drives the arbiter's `req` vector, accepts the one-hot `grant`, runs a fixed-length burst for the granted channel and returns `ack`. It sits between the request sources and the arbiter and closes the req/grant/ack loop. It is also the standard stimulus/consumer for arbiter system tests.

## Interface
- `WIDTH`, 4: number of channels; width of `req`, `grant`, `push`, `served`.
- `BURST`, 2: beats per granted transfer, ≥1.
- `CNT_W`, 2: pending-counter width; per-channel capacity is 2^CNT_W−1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `push` in WIDTH: `push[i]`=1 enqueues one request on channel i this cycle.
- `grant` in WIDTH: one-hot grant from the arbiter.
- `req` out WIDTH: `req[i]`=1 while channel i has pending work.
- `pend_full` out WIDTH: channel i counter at max.
- `served` out WIDTH: one-hot channel currently in burst; 0 otherwise.
- `ack` out 1: high on the last beat of a burst.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: one-cycle pulse on an illegal grant or an aborted burst.

## Operation
- Per-channel counter `cnt[i]`, saturating at 2^CNT_W−1.
- `push[i]` when not full → `cnt[i]+1`. `push[i]` when full → dropped silently.
- Completion decrement on channel i → `cnt[i]−1`.
- Push and completion on the same channel in the same cycle → count unchanged. The push is accepted even if the channel was full.
- `req[i] = (cnt[i]≠0) & ~(state==RELEASE & served_q[i])`, decoded from registers only.
- `pend_full[i] = (cnt[i] == 2^CNT_W−1)`.
- FSM:
  - IDLE:
    - `grant` one-hot and `req` set for that bit → latch channel into `served_q`, beat=0, go to XFER.
    - `grant`=0 → stay in IDLE.
    - `grant` multi-hot, or one-hot to a channel with `req`=0 → `err` pulse, stay in IDLE.
  - XFER:
    - Each cycle with `grant[ch]`=1, beat+1.
    - `ack`=1 while beat==BURST−1; next state RELEASE.
    - `grant[ch]` drops before the last beat → abort: `err` pulse, go to IDLE, no decrement.
  - RELEASE: one cycle. `cnt[ch]` decrements on entry. `req[ch]` is forced low so the arbiter rotates. Next state is IDLE, and `served` clears.
- `served` = `served_q` in XFER, 0 in IDLE and RELEASE.
- `ack`, `busy`, `err` are registered-state decodes: no combinational path from `grant` to `ack`.
- Reset (rst=0 at an edge), including mid-burst:
  - all `cnt`=0, state IDLE, `served_q`=0;
  - outputs `req`=0, `pend_full`=0, `served`=0, `ack`=0, `busy`=0, `err`=0;
  - an interrupted burst is discarded.

## Timing
- Push at edge t → `req[i]` high from cycle t+1.
- Grant accepted in IDLE at edge t:
  - XFER during cycles t+1 … t+BURST;
  - `ack` high during cycle t+BURST;
  - RELEASE at t+BURST+1, with `req[ch]` low, or high again if `cnt` is still ≠0 afterwards, from t+BURST+2;
  - IDLE at t+BURST+2.
- Minimum service period is BURST+2 cycles. Back-to-back grants are accepted in the IDLE cycle immediately after RELEASE.
- `err` is a single cycle, asserted the cycle after the offending edge.

## Test plan
(WIDTH=4, BURST=2, CNT_W=2.)
- Reset: hold rst=0 with random `push`/`grant` → all outputs 0. Release → `req`=0000 until the first push.
- Single service:
  - Stimulus: push[1] at cycle 0, grant=0010 from cycle 1.
  - Response: `served`=0010 in cycles 2–3, `ack`=1 in cycle 3, `req`=0000 in cycle 4, `cnt[1]`=0, `busy`=0 in cycle 5.
- Saturation:
  - Stimulus: four pushes on channel 0.
  - Response: `pend_full`=0001 after the third push; the fourth is dropped. Three services → three `ack` pulses, then `req[0]`=0.
  - Push on channel 0 while full in the decrement cycle → count stays 3.
- Illegal grant:
  - grant=0110 in IDLE with `req`=0110 → `err` pulse, no state change.
  - grant=1000 with `req[3]`=0 → `err` pulse.
- Abort: grant=0001 accepted, then grant=0000 on beat 0 → `err` pulse, IDLE, `cnt[0]` unchanged, `req[0]` still 1.
- Round-robin loop with the arbiter: all four channels each hold 2 pending → 8 `ack` pulses in rotation 0,1,2,3,0,1,2,3; total 32 cycles of service; no `err`.
